tinyalu_core: RTL and testbench

TINYALU_CORE -- requirements
Module: tinyalu_core

---
 rtl/tinyalu_core.sv | 112 +++++++++++
 tb/tb_tinyalu_core.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/tinyalu_core.sv
// Small multi-cycle ALU: single-cycle add/and/xor/no_op, pipelined-latency multiply.
// One command in flight at a time; done/err pulse for one cycle when a command completes.
module tinyalu_core #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result,
    output logic        busy,
    output logic        err
);

    localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 2);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {IDLE, SHORT, MUL, DONE} state_t;

    state_t           state_reg,  state_next;
    logic [7:0]       a_reg,      a_next;
    logic [7:0]       b_reg,      b_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic             done_reg,   done_next;
    logic             err_reg,    err_next;
    logic [15:0]      result_reg, result_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            a_reg      <= 8'h00;
            b_reg      <= 8'h00;
            cnt_reg    <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            result_reg <= 16'h0000;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            cnt_reg    <= cnt_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
            result_reg <= result_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        cnt_next    = cnt_reg;
        done_next   = 1'b0;
        err_next    = 1'b0;
        result_next = result_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next = A;
                    b_next = B;
                    if (op == OP_MUL) begin
                        state_next = MUL;
                        cnt_next   = '0;
                    end else begin
                        // Short ops complete on the accepting edge so done shows up one cycle later.
                        state_next = SHORT;
                        done_next  = 1'b1;
                        err_next   = (op > OP_MUL);
                        case (op)
                            OP_ADD:  result_next = 16'(A) + 16'(B);
                            OP_AND:  result_next = {8'h00, A & B};
                            OP_XOR:  result_next = {8'h00, A ^ B};
                            OP_NOP:  result_next = result_reg;
                            default: result_next = result_reg;
                        endcase
                    end
                end
            end
            SHORT: begin
                state_next = DONE;
            end
            MUL: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next  = DONE;
                    done_next   = 1'b1;
                    result_next = 16'(a_reg) * 16'(b_reg);
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
        endcase
    end

    assign done   = done_reg;
    assign err    = err_reg;
    assign result = result_reg;
    assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_tinyalu_core.sv
// Randomized scoreboard bench for tinyalu_core: driver queues expected completions,
// a negedge monitor checks done/err/result/busy every cycle against them.
module tb_tinyalu_core;

    localparam int MUL_LAT = 3;

    logic        clk;
    logic        reset_n;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;
    logic        busy;
    logic        err;

    tinyalu_core #(.MUL_LAT(MUL_LAT)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .A      (A),
        .B      (B),
        .op     (op),
        .start  (start),
        .done   (done),
        .result (result),
        .busy   (busy),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] res;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          busy_lo = 0;
    int          busy_hi = -1;
    logic [15:0] ref_res = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every cycle, done must match the head of the scoreboard and busy the command window.
    always @(negedge clk) begin
        logic exp_done;
        logic exp_busy;
        exp_t e;
        exp_done = (sb_q.size() > 0) && (sb_q[0].due == cyc);
        exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
        n_cmp++;
        if (done !== exp_done) begin
            n_bad++;
            $display("FAIL done: got %b expected %b (cycle %0d)", done, exp_done, cyc);
        end
        n_cmp++;
        if (busy !== exp_busy) begin
            n_bad++;
            $display("FAIL busy: got %b expected %b (cycle %0d)", busy, exp_busy, cyc);
        end
        if (exp_done) begin
            e = sb_q.pop_front();
            check16("result", result, e.res);
            check16("err", {15'h0, err}, {15'h0, e.err});
            $display("txn done cycle %0d result %h err %b (expected %h %b)", cyc, result, err, e.res, e.err);
        end else begin
            check16("err_idle", {15'h0, err}, 16'h0000);
        end
    end

    // Drive one command in an IDLE cycle and follow it through completion back to IDLE.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o, input int gap);
        int   acc;
        int   lat;
        int   bsy;
        exp_t e;
        start = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        A = a; B = b; op = o; start = 1'b1;
        acc = cyc + 1;
        lat = (o == 3'b100) ? MUL_LAT : 1;
        bsy = (o == 3'b100) ? MUL_LAT : 2;
        case (o)
            3'b001:  ref_res = 16'(int'(a) + int'(b));
            3'b010:  ref_res = {8'h00, a & b};
            3'b011:  ref_res = {8'h00, a ^ b};
            3'b100:  ref_res = 16'(int'(a) * int'(b));
            default: ref_res = ref_res;
        endcase
        e.due = acc + lat - 1;
        e.res = ref_res;
        e.err = (o >= 3'b101);
        sb_q.push_back(e);
        busy_lo = acc;
        busy_hi = acc + bsy - 1;
        $display("txn issue op %0d A %h B %h accept edge %0d", o, a, b, acc);
        for (int i = 0; i <= bsy; i++) begin
            @(posedge clk); #1;
            A = 8'($urandom); B = 8'($urandom); op = 3'($urandom); start = 1'($urandom);
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        reset_n = 1'b0;
        start   = 1'b1;
        A = 8'h12; B = 8'h34; op = 3'b001;
        #1;
        check16("reset_result", result, 16'h0000);
        check16("reset_flags", {13'h0, done, busy, err}, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check16("reset_hold_busy", {15'h0, busy}, 16'h0000);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        issue(8'hFF, 8'h01, 3'b001, 0);
        check16("add_ff_01", result, 16'h0100);
        issue(8'hFF, 8'hFF, 3'b100, 1);
        check16("mul_ff_ff", result, 16'hFE01);
        issue(8'hA5, 8'h0F, 3'b011, 0);
        check16("xor_a5_0f", result, 16'h00AA);
        issue(8'h11, 8'h22, 3'b000, 0);
        check16("noop_hold", result, 16'h00AA);
        issue(8'h33, 8'h44, 3'b110, 2);
        check16("illegal_hold", result, 16'h00AA);
        issue(8'h03, 8'h04, 3'b001, 0);
        check16("add_3_4", result, 16'h0007);
        issue(8'h03, 8'h04, 3'b100, 0);
        check16("mul_3_4", result, 16'h000C);

        for (int n = 0; n < 120; n++) begin
            issue(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        // Multiply aborted by reset in its second cycle: no done, everything cleared.
        A = 8'hFF; B = 8'hFF; op = 3'b100; start = 1'b1;
        e0 = cyc;
        busy_lo = e0 + 1;
        busy_hi = e0 + 1;
        $display("txn issue mul with mid-flight reset, accept edge %0d", e0 + 1);
        @(posedge clk); #1;
        A = 8'h5A; B = 8'hC3; start = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        ref_res = 16'h0000;
        check16("abort_result", result, 16'h0000);
        check16("abort_flags", {13'h0, done, busy, err}, 16'h0000);
        start = 1'b1; op = 3'b001;
        @(posedge clk); #1;
        check16("abort_no_accept", {15'h0, busy}, 16'h0000);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (MUL_LAT + 2) @(posedge clk);
        #1;
        check16("abort_after", {14'h0, busy, done}, 16'h0000);

        issue(8'h00, 8'h00, 3'b000, 0);
        check16("noop_after_reset", result, 16'h0000);
        for (int n = 0; n < 20; n++) begin
            issue(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 0);
        end

        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending: got %0d outstanding completions expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
